nibbler_dmem_responder: RTL and testbench



---
 rtl/nibbler_mem_pkg.sv | 10 +
 rtl/nibbler_dmem_array.sv | 16 +
 rtl/nibbler_dmem_responder.sv | 79 +++++++
 tb/tb_nibbler_dmem_responder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/nibbler_mem_pkg.sv
// nibbler_mem_pkg: shared message-type, FSM-state and counter-width constants for the Nibbler data-memory path
package nibbler_mem_pkg;
   localparam logic MEM_MSG_READ  = 1'b0;
   localparam logic MEM_MSG_WRITE = 1'b1;
   localparam int   CNT_W         = 4;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;
endpackage

// File: rtl/nibbler_dmem_array.sv
// nibbler_dmem_array: 2^P_AWIDTH x 32 word store, synchronous write, asynchronous read, contents never reset
module nibbler_dmem_array #(
   parameter int P_AWIDTH = 10
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic [P_AWIDTH-1:0] i_waddr,
   input  logic [31:0]         i_wdata,
   input  logic [P_AWIDTH-1:0] i_raddr,
   output logic [31:0]         o_rdata
);
   logic [31:0] r_mem [2**P_AWIDTH];
   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/nibbler_dmem_responder.sv
// nibbler_dmem_responder: single-outstanding val/rdy data-memory responder with P_LAT-cycle response latency.
// Define NIBBLER_DMEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned requests via resp_err and suppress their writes.
module nibbler_dmem_responder
   import nibbler_mem_pkg::*;
#(
   parameter int P_AWIDTH = 10,
   parameter int P_LAT    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_val,
   output logic        req_rdy,
   input  logic        req_msg_type,
   input  logic [31:0] req_msg_addr,
   input  logic [31:0] req_msg_data,
   output logic        resp_val,
   input  logic        resp_rdy,
   output logic        resp_msg_type,
   output logic [31:0] resp_msg_data,
   output logic        resp_err
);
   state_t                r_state, w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_type, r_err;
   logic [P_AWIDTH-1:0]   r_idx, w_idx, w_rd_idx;
   logic [31:0]           r_data, w_rdata;
   logic                  w_idle, w_acc, w_mis, w_we, w_to_resp, w_rd_type, w_rd_err, w_unused;
   assign w_idle   = r_state == ST_IDLE;
   assign w_acc    = req_val && w_idle;
   assign w_idx    = req_msg_addr[P_AWIDTH+1:2];
`ifdef NIBBLER_DMEM_RESPONDER_ALIGN_CHECK_EN
   assign w_mis    = |req_msg_addr[1:0];
`else
   assign w_mis    = 1'b0;
`endif
   assign w_unused = &{1'b0, req_msg_addr[31:P_AWIDTH+2], req_msg_addr[1:0]};
   assign w_we     = w_acc && req_msg_type == MEM_MSG_WRITE && !w_mis;
   // With P_LAT == 1 the response is captured on the accept edge, so read through the live request
   assign w_rd_idx  = w_idle ? w_idx : r_idx;
   assign w_rd_type = w_idle ? req_msg_type : r_type;
   assign w_rd_err  = w_idle ? w_mis : r_err;
   assign w_next = w_idle ? (w_acc ? (P_LAT == 1 ? ST_RESP : ST_WAIT) : ST_IDLE)
                 : r_state == ST_WAIT ? (r_cnt == CNT_W'(1) ? ST_RESP : ST_WAIT)
                 : (r_state == ST_RESP && !resp_rdy) ? ST_RESP : ST_IDLE;
   assign w_to_resp = w_next == ST_RESP && r_state != ST_RESP;
   nibbler_dmem_array #(.P_AWIDTH(P_AWIDTH)) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_idx),
      .i_wdata (req_msg_data),
      .i_raddr (w_rd_idx),
      .o_rdata (w_rdata)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_type  <= MEM_MSG_READ;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_type <= req_msg_type;
            r_idx  <= w_idx;
            r_err  <= w_mis;
         end
         if (w_acc && P_LAT > 1) r_cnt <= CNT_W'(P_LAT - 1);
         else if (r_state == ST_WAIT) r_cnt <= r_cnt - CNT_W'(1);
         if (w_to_resp) r_data <= (w_rd_type == MEM_MSG_WRITE || w_rd_err) ? '0 : w_rdata;
      end
   end
   assign req_rdy       = w_idle;
   assign resp_val      = r_state == ST_RESP;
   assign resp_msg_type = r_type;
   assign resp_msg_data = r_data;
   assign resp_err      = r_err;
endmodule

// File: tb/tb_nibbler_dmem_responder.sv
// tb_nibbler_dmem_responder: directed vector table plus stall, throughput and mid-operation reset sequences
module tb_nibbler_dmem_responder;
   localparam int P_AWIDTH = 10;
   localparam int P_LAT    = 2;
`ifdef NIBBLER_DMEM_RESPONDER_ALIGN_CHECK_EN
   localparam bit ALN = 1'b1;
`else
   localparam bit ALN = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset, req_val, req_rdy, req_msg_type, resp_val, resp_rdy, resp_msg_type, resp_err;
   logic [31:0] req_msg_addr, req_msg_data, resp_msg_data;
   int          checks = 0;
   int          failures = 0;
   typedef struct {
      logic        t;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;
   vec_t vecs[13];
   always #5 clk = ~clk;
   nibbler_dmem_responder #(.P_AWIDTH(P_AWIDTH), .P_LAT(P_LAT)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_val       (req_val),
      .req_rdy       (req_rdy),
      .req_msg_type  (req_msg_type),
      .req_msg_addr  (req_msg_addr),
      .req_msg_data  (req_msg_data),
      .resp_val      (resp_val),
      .resp_rdy      (resp_rdy),
      .resp_msg_type (resp_msg_type),
      .resp_msg_data (resp_msg_data),
      .resp_err      (resp_err)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   task automatic wait_resp(input string name);
      int n = 0;
      while (!resp_val && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!resp_val) chk({name, "_timeout"}, 32'(resp_val), 32'd1);
   endtask
   task automatic run_vec(input int i);
      vec_t v = vecs[i];
      int lat = 0;
      @(negedge clk);
      chk($sformatf("v%0d_req_rdy_idle", i), 32'(req_rdy), 32'd1);
      req_val = 1'b1; req_msg_type = v.t; req_msg_addr = v.a; req_msg_data = v.d;
      do begin
         @(negedge clk);
         if (lat == 0) req_val = 1'b0;
         lat++;
      end while (!resp_val && lat < 20);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(P_LAT));
      chk($sformatf("v%0d_req_rdy_busy", i), 32'(req_rdy), 32'd0);
      chk($sformatf("v%0d_type", i), 32'(resp_msg_type), 32'(v.t));
      chk($sformatf("v%0d_data", i), resp_msg_data, v.exp_data);
      chk($sformatf("v%0d_err", i), 32'(resp_err), 32'(v.exp_err));
      @(negedge clk);
      chk($sformatf("v%0d_resp_val_done", i), 32'(resp_val), 32'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end
   initial begin
      int n_idle, n_resp;
      logic seen;
      vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0004, 32'hA5A5_0004, 32'h0, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0, 32'hA5A5_0004, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0, 32'h1111_1111, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0, 1'b0};
      vecs[7]  = '{1'b0, 32'h0000_1FFC, 32'h0, 32'hCAFE_F00D, 1'b0};
      vecs[8]  = '{1'b1, 32'h0000_0042, 32'h1234_5678, 32'h0, ALN};
      vecs[9]  = '{1'b0, 32'h0000_0040, 32'h0, ALN ? 32'hDEAD_BEEF : 32'h1234_5678, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_0043, 32'h0, ALN ? 32'h0 : 32'h1234_5678, ALN};
      vecs[11] = '{1'b1, 32'h0000_0004, 32'h0, 32'h0, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0, 1'b0};
      reset = 1'b0; req_val = 1'b0; req_msg_type = 1'b0; req_msg_addr = '0; req_msg_data = '0; resp_rdy = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_req_rdy", 32'(req_rdy), 32'd1);
      chk("rst_resp_val", 32'(resp_val), 32'd0);
      chk("rst_resp_type", 32'(resp_msg_type), 32'd0);
      chk("rst_resp_data", resp_msg_data, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 13; i++) run_vec(i);
      // Stall: response held with resp_rdy low while a new request waits at the input
      @(negedge clk);
      resp_rdy = 1'b0; req_val = 1'b1; req_msg_type = 1'b0; req_msg_addr = 32'h1000;
      @(negedge clk);
      req_msg_addr = 32'h40;
      wait_resp("stall");
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d_val", c), 32'(resp_val), 32'd1);
         chk($sformatf("stall%0d_data", c), resp_msg_data, 32'h1111_1111);
         chk($sformatf("stall%0d_req_rdy", c), 32'(req_rdy), 32'd0);
         @(negedge clk);
      end
      req_val = 1'b0; resp_rdy = 1'b1;
      @(negedge clk);
      chk("stall_release_val", 32'(resp_val), 32'd0);
      chk("stall_release_rdy", 32'(req_rdy), 32'd1);
      // Back-to-back reads: one accept every P_LAT+1 cycles
      n_idle = 0; n_resp = 0;
      req_val = 1'b1; req_msg_type = 1'b0; req_msg_addr = 32'h0;
      repeat (3 * (P_LAT + 1)) begin
         if (req_rdy) n_idle++;
         if (resp_val) n_resp++;
         @(negedge clk);
      end
      req_val = 1'b0;
      chk("thru_accepts", 32'(n_idle), 32'd3);
      chk("thru_resps", 32'(n_resp), 32'd3);
      repeat (3) @(negedge clk);
      // Reset during WAIT: accepted write survives, no response appears
      req_val = 1'b1; req_msg_type = 1'b1; req_msg_addr = 32'h80; req_msg_data = 32'h7777_7777;
      @(negedge clk);
      req_val = 1'b0;
      chk("wait_busy", 32'(req_rdy), 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("wait_rst_val", 32'(resp_val), 32'd0);
      chk("wait_rst_rdy", 32'(req_rdy), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen |= resp_val;
      end
      chk("wait_rst_no_resp", 32'(seen), 32'd0);
      // Reset during RESP clears the registered response at once
      resp_rdy = 1'b0; req_val = 1'b1; req_msg_type = 1'b0; req_msg_addr = 32'h40;
      @(negedge clk);
      req_val = 1'b0;
      wait_resp("resp_rst");
      chk("resp_rst_pre_data", resp_msg_data, ALN ? 32'hDEAD_BEEF : 32'h1234_5678);
      #2 reset = 1'b0;
      #1;
      chk("resp_rst_val", 32'(resp_val), 32'd0);
      chk("resp_rst_data", resp_msg_data, 32'd0);
      chk("resp_rst_rdy", 32'(req_rdy), 32'd1);
      @(negedge clk);
      reset = 1'b1; resp_rdy = 1'b1;
      vecs[0] = '{1'b0, 32'h0000_0080, 32'h0, 32'h7777_7777, 1'b0};
      run_vec(0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
